// File: rtl/tb_run_sequencer_pkg.sv
// Shared definitions for the measurement-run sequencer: state codes and default phase lengths.
package tb_run_sequencer_pkg;

  localparam int STATE_W               = 3;
  localparam int DEFAULT_RESET_CYCLES  = 4;
  localparam int DEFAULT_SETTLE_CYCLES = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_FREEZE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/tb_phase_counter.sv
// Loadable down-counter shared by the CLEAR, RUN and FREEZE phases; holds at zero.
module tb_phase_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (load)
      count_q <= load_val;
    else if (dec && (count_q != '0))
      count_q <= count_q - WIDTH'(1);
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/tb_run_sequencer.sv
// Sequences one testbench measurement run: reset pulse, enabled run of programmed length,
// then freeze so counters can be read stably. Outputs are a Moore decode of registered state.
module tb_run_sequencer
  import tb_run_sequencer_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int RESET_CYCLES  = DEFAULT_RESET_CYCLES,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [WIDTH-1:0]   i_run_len,
  output logic               o_tb_reset,
  output logic               o_tb_enable,
  output logic               o_tb_freeze,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted,
  output logic [WIDTH-1:0]   o_elapsed,
  output logic [STATE_W-1:0] o_state
);

  state_t           state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [WIDTH-1:0] cnt_load_val;
  logic [WIDTH-1:0] run_len_q, elapsed_q;
  logic             aborted_q;
  logic             start_accept, abort_taken;

  tb_phase_counter #(.WIDTH(WIDTH)) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Counter is loaded with (phase length - 1) on entry so zero marks the final cycle.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    start_accept = 1'b0;
    abort_taken  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d      = ST_CLEAR;
          start_accept = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = WIDTH'(RESET_CYCLES - 1);
        end else if (i_abort && (state_q == ST_DONE)) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (i_abort) begin
          state_d     = ST_IDLE;
          abort_taken = 1'b1;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          if (run_len_q == '0) begin
            state_d      = ST_FREEZE;
            cnt_load_val = WIDTH'(SETTLE_CYCLES - 1);
          end else begin
            state_d      = ST_RUN;
            cnt_load_val = run_len_q - WIDTH'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        // Terminal count takes precedence over a coincident abort.
        if (cnt_zero || i_abort) begin
          state_d      = ST_FREEZE;
          abort_taken  = !cnt_zero;
          cnt_load     = 1'b1;
          cnt_load_val = WIDTH'(SETTLE_CYCLES - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_FREEZE: begin
        if (cnt_zero)
          state_d = ST_DONE;
        else
          cnt_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_len_q <= '0;
      elapsed_q <= '0;
      aborted_q <= 1'b0;
    end else if (start_accept) begin
      run_len_q <= i_run_len;
      elapsed_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      if ((state_q == ST_RUN) && (elapsed_q != '1))
        elapsed_q <= elapsed_q + WIDTH'(1);
      if (abort_taken)
        aborted_q <= 1'b1;
    end
  end

  assign o_tb_reset  = (state_q == ST_CLEAR);
  assign o_tb_enable = (state_q == ST_RUN);
  assign o_tb_freeze = (state_q == ST_FREEZE) || (state_q == ST_DONE);
  assign o_busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_FREEZE);
  assign o_done      = (state_q == ST_DONE);
  assign o_aborted   = aborted_q;
  assign o_elapsed   = elapsed_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_tb_run_sequencer.sv
// Directed self-checking bench for tb_run_sequencer (RESET_CYCLES=4, SETTLE_CYCLES=8).
module tb_tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_run_len = '0;
  logic        o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted;
  logic [31:0] o_elapsed;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;

  tb_run_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_run_len   (i_run_len),
    .o_tb_reset  (o_tb_reset),
    .o_tb_enable (o_tb_enable),
    .o_tb_freeze (o_tb_freeze),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .o_elapsed   (o_elapsed),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  // Output pairs that must never be high together, checked every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((o_tb_reset && o_tb_enable) || (o_tb_enable && o_tb_freeze)) begin
        errors++;
        $display("[TB] FAIL exclusive: reset=%0b enable=%0b freeze=%0b, required no overlap",
                 o_tb_reset, o_tb_enable, o_tb_freeze);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (o_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_run(input bit drop_start, input int budget,
                             output int rst_c, output int en_c, output int frz_c,
                             output int first_en, output bit ok);
    rst_c = 0; en_c = 0; frz_c = 0; first_en = -1; ok = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (drop_start) i_start = 1'b0;
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      if (o_tb_reset) rst_c++;
      if (o_tb_enable) begin
        en_c++;
        if (first_en < 0) first_en = i;
      end
      if (o_tb_freeze) frz_c++;
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 000000",
               {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted});
    end
    checks++;
    if (o_state !== 3'd0 || o_elapsed !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: state=%0d elapsed=%0d, required 0/0", o_state, o_elapsed);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_normal_run();
    int r, e, f, fe;
    bit ok;
    i_run_len = 32'd10;
    i_start   = 1'b1;
    measure_run(1'b1, 200, r, e, f, fe, ok);
    checks++;
    if (!ok || r != 4 || e != 10 || f != 8) begin
      errors++;
      $display("[TB] FAIL normal_phases: done=%0b reset=%0d enable=%0d freeze=%0d, required 1/4/10/8",
               ok, r, e, f);
    end
    checks++;
    if (fe != 5) begin
      errors++;
      $display("[TB] FAIL start_latency: first enable cycle %0d, required 5", fe);
    end
    checks++;
    if (o_elapsed !== 32'd10 || o_aborted !== 1'b0 || o_state !== 3'd4 || o_tb_freeze !== 1'b1) begin
      errors++;
      $display("[TB] FAIL normal_done: elapsed=%0d aborted=%0b state=%0d freeze=%0b, required 10/0/4/1",
               o_elapsed, o_aborted, o_state, o_tb_freeze);
    end
  endtask

  task automatic test_zero_length();
    int r, e, f, fe;
    bit ok;
    i_run_len = 32'd0;
    i_start   = 1'b1;
    measure_run(1'b1, 200, r, e, f, fe, ok);
    checks++;
    if (!ok || r != 4 || e != 0 || f != 8) begin
      errors++;
      $display("[TB] FAIL zero_len_phases: done=%0b reset=%0d enable=%0d freeze=%0d, required 1/4/0/8",
               ok, r, e, f);
    end
    checks++;
    if (o_elapsed !== 32'd0 || o_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_len_done: elapsed=%0d done=%0b, required 0/1", o_elapsed, o_done);
    end
  endtask

  task automatic test_abort_run();
    int r, e, f, fe;
    bit ok;
    i_run_len = 32'd100;
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    wait_state(3'd2, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL abort_reach_run: state=%0d, required 2", o_state);
    end
    repeat (36) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    checks++;
    if (o_state !== 3'd3 || o_elapsed !== 32'd37 || o_aborted !== 1'b1 || o_tb_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_freeze: state=%0d elapsed=%0d aborted=%0b enable=%0b, required 3/37/1/0",
               o_state, o_elapsed, o_aborted, o_tb_enable);
    end
    wait_state(3'd4, 20, ok);
    checks++;
    if (!ok || o_aborted !== 1'b1 || o_elapsed !== 32'd37) begin
      errors++;
      $display("[TB] FAIL abort_done: reached=%0b aborted=%0b elapsed=%0d, required 1/1/37",
               ok, o_aborted, o_elapsed);
    end
    i_run_len = 32'd5;
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_state !== 3'd1 || o_aborted !== 1'b0 || o_elapsed !== 32'd0) begin
      errors++;
      $display("[TB] FAIL restart_clears: state=%0d aborted=%0b elapsed=%0d, required 1/0/0",
               o_state, o_aborted, o_elapsed);
    end
    measure_run(1'b0, 100, r, e, f, fe, ok);
    checks++;
    if (!ok || e != 5 || o_elapsed !== 32'd5) begin
      errors++;
      $display("[TB] FAIL restart_run: done=%0b enable=%0d elapsed=%0d, required 1/5/5", ok, e, o_elapsed);
    end
  endtask

  task automatic test_abort_terminal();
    bit ok;
    i_run_len = 32'd10;
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    wait_state(3'd2, 20, ok);
    repeat (9) step();
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    checks++;
    if (!ok || o_state !== 3'd3 || o_aborted !== 1'b0 || o_elapsed !== 32'd10) begin
      errors++;
      $display("[TB] FAIL abort_terminal: state=%0d aborted=%0b elapsed=%0d, required 3/0/10",
               o_state, o_aborted, o_elapsed);
    end
    wait_state(3'd4, 20, ok);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    checks++;
    if (!ok || o_state !== 3'd0 || o_tb_freeze !== 1'b0 || o_elapsed !== 32'd10) begin
      errors++;
      $display("[TB] FAIL done_abort: state=%0d freeze=%0b elapsed=%0d, required 0/0/10",
               o_state, o_tb_freeze, o_elapsed);
    end
  endtask

  task automatic test_clear_abort();
    i_run_len = 32'd7;
    i_start   = 1'b1;
    i_abort   = 1'b1;
    step();
    i_start = 1'b0;
    checks++;
    if (o_state !== 3'd1 || o_tb_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_wins: state=%0d tb_reset=%0b, required 1/1", o_state, o_tb_reset);
    end
    step();
    i_abort = 1'b0;
    checks++;
    if (o_state !== 3'd0 || o_tb_reset !== 1'b0 || o_aborted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_abort: state=%0d tb_reset=%0b aborted=%0b, required 0/0/1",
               o_state, o_tb_reset, o_aborted);
    end
  endtask

  task automatic test_back_to_back();
    int r, e, f, fe;
    bit ok;
    i_run_len = 32'd6;
    i_start   = 1'b1;
    step();
    i_run_len = 32'd3;
    measure_run(1'b0, 100, r, e, f, fe, ok);
    checks++;
    if (!ok || r != 3 || e != 6) begin
      errors++;
      $display("[TB] FAIL held_start_len: done=%0b reset=%0d enable=%0d, required 1/3/6", ok, r, e);
    end
    step();
    checks++;
    if (o_state !== 3'd1 || o_done !== 1'b0 || o_tb_reset !== 1'b1) begin
      errors++;
      $display("[TB] FAIL held_restart: state=%0d done=%0b tb_reset=%0b, required 1/0/1",
               o_state, o_done, o_tb_reset);
    end
    i_start = 1'b0;
    measure_run(1'b0, 100, r, e, f, fe, ok);
    checks++;
    if (!ok || e != 3 || o_elapsed !== 32'd3) begin
      errors++;
      $display("[TB] FAIL relatch_len: done=%0b enable=%0d elapsed=%0d, required 1/3/3", ok, e, o_elapsed);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    i_run_len = 32'd50;
    i_start   = 1'b1;
    step();
    i_start = 1'b0;
    wait_state(3'd2, 20, ok);
    repeat (5) step();
    reset = 1'b1;
    #1;
    checks++;
    if (!ok || {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_flags: reached=%0b flags=%b, required 1/000000", ok,
               {o_tb_reset, o_tb_enable, o_tb_freeze, o_busy, o_done, o_aborted});
    end
    checks++;
    if (o_state !== 3'd0 || o_elapsed !== 32'd0) begin
      errors++;
      $display("[TB] FAIL async_reset_state: state=%0d elapsed=%0d, required 0/0", o_state, o_elapsed);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_zero_length();
    test_abort_run();
    test_abort_terminal();
    test_clear_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
